// File: rtl/key_expander.sv
// AES-128 key expander: latches a cipher key and derives round keys 1..10 into an 11-slot register file.
// Latency: one round per cycle; key_valid rises 11 edges after the accepted start; rd_key is 1 cycle after rd_idx.
// Backpressure: start is accepted only while ready=1; a start during expansion is dropped.

// AES forward S-box, pure lookup. Byte 0x00 sits in the most significant byte of the table.
module sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] base;

   // Byte offset of the selected entry, counted from the top of the table.
   always_comb begin
      base = {din, 3'b000};
      dout = TABLE[11'd2047 - base -: 8];
   end
endmodule

module key_expander (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         ready,
   output logic         key_valid,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key,
   output logic [3:0]   round
);
   typedef enum logic [1:0] {IDLE, EXPAND, READY_KEYS} state_t;

   state_t        state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic          load;
   logic          wr;
   logic          kv_q;
   logic [127:0]  slot [0:10];
   logic [3:0]    prev_idx;
   logic [127:0]  prev_key;
   logic [127:0]  next_key;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot, sub, temp;
   logic [31:0]   n0, n1, n2, n3;
   logic [7:0]    rc;

   // Control state and round counter; reset wins over any start in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         // Lags entry into READY_KEYS by one edge; a restart clears it at once.
         kv_q    <= (state_q == READY_KEYS) && !load;
      end
   end

   // Next-state logic: accept start when idle or holding keys, then step one round per cycle.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      load    = 1'b0;
      wr      = 1'b0;
      case (state_q)
         IDLE, READY_KEYS: begin
            if (start && rst_n) begin
               load    = 1'b1;
               state_d = EXPAND;
               round_d = 4'd1;
            end
         end
         EXPAND: begin
            wr = rst_n;
            if (round_q == 4'd10) begin
               state_d = READY_KEYS;
               round_d = 4'd0;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   assign ready     = (state_q != EXPAND);
   assign key_valid = kv_q;
   assign round     = round_q;

   // Round constant for the round being computed.
   always_comb begin
      case (round_q)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
   end

   // Previous round key words; round 0 never reaches the write path, the guard only keeps the index in range.
   always_comb begin
      prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
      prev_key = slot[prev_idx];
      w0       = prev_key[127:96];
      w1       = prev_key[95:64];
      w2       = prev_key[63:32];
      w3       = prev_key[31:0];
      rot      = {w3[23:0], w3[31:24]};
   end

   for (genvar i = 0; i < 4; i++) begin : g_sub
      sbox u_sbox (
         .din  (rot[8*i +: 8]),
         .dout (sub[8*i +: 8])
      );
   end

   // Word chain of one key-schedule round.
   always_comb begin
      temp     = sub ^ {rc, 24'h0};
      n0       = w0 ^ temp;
      n1       = n0 ^ w1;
      n2       = n1 ^ w2;
      n3       = n2 ^ w3;
      next_key = {n0, n1, n2, n3};
   end

   // Round-key storage; contents need no reset since key_valid gates their meaning.
   always_ff @(posedge clk) begin
      if (load) slot[0] <= key_in;
      if (wr)   slot[round_q] <= next_key;
   end

   // Registered read port; indices past the last round return zero.
   always_ff @(posedge clk) begin
      if (!rst_n)                rd_key <= 128'h0;
      else if (rd_idx <= 4'd10)  rd_key <= slot[rd_idx];
      else                       rd_key <= 128'h0;
   end
endmodule

// File: tb/tb_key_expander.sv
module tb_key_expander;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         ready;
   logic         key_valid;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic [3:0]   round;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K_ZERO = 128'h0;
   localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [12];

   key_expander dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .ready     (ready),
      .key_valid (key_valid),
      .rd_idx    (rd_idx),
      .rd_key    (rd_key),
      .round     (round)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge (E0), then count edges until key_valid; 11 is expected.
   task automatic expand(input logic [127:0] k);
      int cyc;
      key_in = k;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      cyc    = 0;
      while (!key_valid && cyc < 30) begin
         tick();
         cyc++;
      end
      check("expand_latency", 128'(cyc), 128'd11);
   endtask

   task automatic read_key(input logic [3:0] idx, output logic [127:0] k);
      rd_idx = idx;
      tick();
      k = rd_key;
   endtask

   task automatic wait_round(input logic [3:0] r);
      int cyc;
      cyc = 0;
      while (round != r && cyc < 30) begin
         tick();
         cyc++;
      end
      check("wait_round", 128'(round), 128'(r));
   endtask

   initial begin
      logic [127:0] k;
      logic [127:0] cur;
      logic         have;
      logic         kv_seen;

      vecs[0]  = '{K_FIPS, 4'd0,  K_FIPS};
      vecs[1]  = '{K_FIPS, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2]  = '{K_FIPS, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3]  = '{K_FIPS, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[4]  = '{K_FIPS, 4'd11, 128'h0};
      vecs[5]  = '{K_ZERO, 4'd1,  128'h62636363626363636263636362636363};
      vecs[6]  = '{K_ZERO, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
      vecs[7]  = '{K_ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[8]  = '{K_ZERO, 4'd15, 128'h0};
      vecs[9]  = '{K_SEQ,  4'd0,  K_SEQ};
      vecs[10] = '{K_SEQ,  4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
      vecs[11] = '{K_SEQ,  4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

      // Reset with start held high: the start must be ignored.
      rst_n  = 1'b0;
      start  = 1'b1;
      key_in = K_FIPS;
      rd_idx = 4'd0;
      tick();
      tick();
      check("rst_ready", 128'(ready), 128'd1);
      check("rst_key_valid", 128'(key_valid), 128'd0);
      check("rst_round", 128'(round), 128'd0);
      check("rst_rd_key", rd_key, 128'h0);
      rst_n = 1'b1;
      start = 1'b0;
      tick();
      check("post_rst_ready", 128'(ready), 128'd1);
      check("post_rst_round", 128'(round), 128'd0);

      // Cycle-by-cycle profile of one expansion.
      key_in = K_FIPS;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         check($sformatf("prof_round_%0d", c), 128'(round), (c < 10) ? 128'(c + 1) : 128'd0);
         check($sformatf("prof_ready_%0d", c), 128'(ready), (c < 10) ? 128'd0 : 128'd1);
         check($sformatf("prof_kv_%0d", c), 128'(key_valid), (c >= 11) ? 128'd1 : 128'd0);
         if (c < 11) tick();
      end
      cur  = K_FIPS;
      have = 1'b1;

      // Table of known round keys.
      for (int i = 0; i < 12; i++) begin
         if (!have || vecs[i].key != cur) begin
            expand(vecs[i].key);
            cur  = vecs[i].key;
            have = 1'b1;
         end
         read_key(vecs[i].idx, k);
         check($sformatf("vec%0d", i), k, vecs[i].exp);
      end

      // Start pulsed mid-expansion is ignored.
      key_in = K_FIPS;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_round(4'd5);
      key_in = K_SEQ;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      check("ign_round", 128'(round), 128'd6);
      check("ign_ready", 128'(ready), 128'd0);
      wait_round(4'd0);
      tick();
      check("ign_kv", 128'(key_valid), 128'd1);
      read_key(4'd10, k);
      check("ign_r10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_key(4'd0, k);
      check("ign_r0", k, K_FIPS);

      // Reset for one cycle at round 6 aborts; no valid without a new start.
      key_in = K_ZERO;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_round(4'd6);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_ready", 128'(ready), 128'd1);
      check("abort_kv", 128'(key_valid), 128'd0);
      check("abort_round", 128'(round), 128'd0);
      check("abort_rd_key", rd_key, 128'h0);
      kv_seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (key_valid) kv_seen = 1'b1;
      end
      check("abort_no_kv", 128'(kv_seen), 128'd0);

      // Restart from READY_KEYS with a new key.
      expand(K_FIPS);
      key_in = K_SEQ;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      check("restart_kv_drop", 128'(key_valid), 128'd0);
      check("restart_ready", 128'(ready), 128'd0);
      for (int c = 1; c < 11; c++) tick();
      check("restart_kv_pre", 128'(key_valid), 128'd0);
      tick();
      check("restart_kv_rise", 128'(key_valid), 128'd1);
      read_key(4'd10, k);
      check("restart_r10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      read_key(4'd12, k);
      check("restart_r12", k, 128'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
